serial_bit_packer: RTL

- Downstream stage for the single-bit port fabric: consumes a 1-bit sample stream, such as an `out1`-style output of a port-level module, and packs it LSB-first into WIDTH-bit words.
- Upstream interface is valid/ready with a frame terminator (`in_last`). Downstream interface is a registered valid/ready word port that carries a length and a last flag.
- An optional idle timeout flushes stale partial words. Saturating word and frame counters are provided for debug visibility.

---
 rtl/serial_bit_packer_pkg.sv | 14 +
 rtl/sat_counter.sv | 18 +
 rtl/serial_bit_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_bit_packer_pkg.sv
// Shared types and helpers for the serial bit packer.
package serial_bit_packer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int len_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (inc && !(&q))
         q <= q + W'(1);
   end

endmodule

// File: rtl/serial_bit_packer.sv
// Packs a 1-bit valid/ready stream LSB-first into WIDTH-bit words with length/last.
// state | meaning
// IDLE  | no bits collected, no word held
// ACCUM | 0 < cnt < WIDTH bits collected
// HOLD  | completed word presented on the output port
module serial_bit_packer
   import serial_bit_packer_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 0,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_bit,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [len_w(WIDTH)-1:0]   out_len,
   output logic                      out_last,
   output logic [CNT_W-1:0]          word_count,
   output logic [CNT_W-1:0]          frame_count
);

   localparam int            LW       = len_w(WIDTH);
   localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;
   localparam bit            TMO_EN   = (TIMEOUT > 0);

   state_t            state, state_nx;
   logic [WIDTH-1:0]  shreg;
   logic [WIDTH-1:0]  shreg_new;
   logic [LW-1:0]     cnt;
   logic [TW-1:0]     idle_tmr;
   logic              accept, xfer, complete, fire;

   assign out_valid = (state == HOLD);
   assign in_ready  = ~out_valid | out_ready;
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;

   // Bits above cnt are always zero, so OR-ing in the new bit is enough.
   assign shreg_new = shreg | (WIDTH'(in_bit) << cnt);
   assign complete  = accept & (in_last | (cnt == LW'(WIDTH - 1)));
   assign fire      = TMO_EN && (state == ACCUM) && !accept && (idle_tmr == '0);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (complete)    state_nx = HOLD;
            else if (accept) state_nx = ACCUM;
         end
         ACCUM: begin
            if (complete || fire) state_nx = HOLD;
         end
         HOLD: begin
            if (complete)    state_nx = HOLD;
            else if (accept) state_nx = ACCUM;
            else if (xfer)   state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         cnt      <= '0;
         out_data <= '0;
         out_len  <= '0;
         out_last <= 1'b0;
      end else if (complete) begin
         out_data <= shreg_new;
         out_len  <= cnt + LW'(1);
         out_last <= in_last;
         shreg    <= '0;
         cnt      <= '0;
      end else if (fire) begin
         out_data <= shreg;
         out_len  <= cnt;
         out_last <= 1'b0;
         shreg    <= '0;
         cnt      <= '0;
      end else if (accept) begin
         shreg <= shreg_new;
         cnt   <= cnt + LW'(1);
      end
   end

   // Idle timer counts down from TIMEOUT-1; reaching zero with no bit flushes.
   always_ff @(posedge clk) begin
      if (rst)
         idle_tmr <= TMR_LOAD;
      else if (state != ACCUM || accept)
         idle_tmr <= TMR_LOAD;
      else if (idle_tmr != '0)
         idle_tmr <= idle_tmr - TW'(1);
   end

   sat_counter #(.W(CNT_W)) u_word_cnt (
      .clk (clk),
      .rst (rst),
      .inc (xfer),
      .q   (word_count)
   );

   sat_counter #(.W(CNT_W)) u_frame_cnt (
      .clk (clk),
      .rst (rst),
      .inc (xfer & out_last),
      .q   (frame_count)
   );

endmodule
